// File: rtl/demux_1_to_4.sv
// Registered 1-to-4 stream distributor with a one-entry holding register per channel.
// Optional broadcast to all four channels is enabled with `define DEMUX_BROADCAST_EN.
module demux_1_to_4 #(
    parameter int unsigned data_width = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [data_width-1:0]   in_data,
    input  logic [1:0]              in_dest,
    input  logic                    in_valid,
    output logic                    in_ready,
`ifdef DEMUX_BROADCAST_EN
    input  logic                    in_bcast,
`endif
    output logic [4*data_width-1:0] out_data,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready
);

    localparam int unsigned NUM_CH = 4;

    logic [NUM_CH-1:0]     valid_q;
    logic [NUM_CH-1:0]     valid_d;
    logic [data_width-1:0] hold_q [NUM_CH];
    logic [data_width-1:0] hold_d [NUM_CH];
    logic [NUM_CH-1:0]     ch_free_c;
    logic [NUM_CH-1:0]     wr_sel_c;

    // A channel can take a word if it is empty or is being drained this cycle.
    always_comb begin
        ch_free_c = ~valid_q | out_ready;
        in_ready  = ch_free_c[in_dest];
        wr_sel_c  = '0;
`ifdef DEMUX_BROADCAST_EN
        if (in_bcast) begin
            in_ready = &ch_free_c;
        end
        if (in_valid && in_ready) begin
            wr_sel_c = in_bcast ? {NUM_CH{1'b1}} : (NUM_CH'(1) << in_dest);
        end
`else
        if (in_valid && in_ready) begin
            wr_sel_c = NUM_CH'(1) << in_dest;
        end
`endif
    end

    // Per-channel next state: a write wins over a drain so refill has no bubble.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < NUM_CH; k++) begin
            hold_d[k] = hold_q[k];
            if (wr_sel_c[k]) begin
                valid_d[k] = 1'b1;
                hold_d[k]  = in_data;
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < NUM_CH; k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

    assign out_valid = valid_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_data[g*data_width +: data_width] = hold_q[g];
    end

endmodule

// File: tb/tb_demux_1_to_4.sv
// Self-checking bench for demux_1_to_4: queue-based channel model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_demux_1_to_4;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_valid;
    logic          in_ready;
    logic          in_bcast;
    logic [4*DW-1:0] out_data;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;

    int checks = 0;
    int errors = 0;

    demux_1_to_4 #(.data_width(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef DEMUX_BROADCAST_EN
        .in_bcast  (in_bcast),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Channel model: each channel is a queue of capacity one; mlast keeps the stale word.
    logic [DW-1:0] mq [4][$];
    logic [DW-1:0] mlast [4] = '{default: '0};
    logic          m_acc;
    logic [3:0]    m_tgt;
    logic [3:0]    exp_valid;
    logic [127:0]  exp_data;

    function automatic logic model_free(input int k);
        return (mq[k].size() == 0) || out_ready[k];
    endfunction

    function automatic logic model_ready();
        logic all_free;
        all_free = 1'b1;
        for (int k = 0; k < 4; k++) all_free = all_free & model_free(k);
`ifdef DEMUX_BROADCAST_EN
        if (in_bcast) return all_free;
`endif
        return model_free(int'(in_dest));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                mlast[k] = '0;
            end
        end else begin
            m_acc = in_valid && model_ready();
            m_tgt = '0;
            if (m_acc) begin
`ifdef DEMUX_BROADCAST_EN
                if (in_bcast) m_tgt = 4'hF;
                else          m_tgt[in_dest] = 1'b1;
`else
                m_tgt[in_dest] = 1'b1;
`endif
            end
            for (int k = 0; k < 4; k++) begin
                if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
            end
            for (int k = 0; k < 4; k++) begin
                if (m_tgt[k]) begin
                    mq[k].push_back(in_data);
                    mlast[k] = in_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 4; k++) begin
                exp_valid[k] = (mq[k].size() != 0);
                exp_data[k*DW +: DW] = (mq[k].size() != 0) ? mq[k][0] : mlast[k];
            end
            chk("model_out_valid", 128'(out_valid), 128'(exp_valid));
            chk("model_out_data", out_data, exp_data);
            chk("model_in_ready", 128'(in_ready), 128'(model_ready()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [1:0] dest);
        in_data  = d;
        in_dest  = dest;
        in_valid = 1'b1;
    endtask

    initial begin
        in_data = '0; in_dest = '0; in_valid = 1'b0; in_bcast = 1'b0;
        out_ready = 4'hF; reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("reset_out_valid", 128'(out_valid), 128'h0);
        chk("reset_out_data", out_data, 128'h0);

        // Routing: one word per channel, one cycle latency.
        tick();
        send(32'hA000_0000, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) send(32'hA000_0000 + DW'(i + 1), 2'(i + 1));
            else       in_valid = 1'b0;
            #1;
            chk("route_valid", 128'(out_valid), 128'(4'b0001 << i));
            chk("route_data", 128'(out_data[i*DW +: DW]), 128'(32'hA000_0000 + DW'(i)));
        end
        tick();
        chk("route_idle", 128'(out_valid), 128'h0);

        // Backpressure isolation on channel 0.
        out_ready = 4'b1110;
        send(32'h11, 2'd0);
        #1 chk("bp_first_ready", 128'(in_ready), 128'h1);
        tick();
        send(32'h22, 2'd0);
        #1 chk("bp_blocked_ready", 128'(in_ready), 128'h0);
        chk("bp_hold_11", 128'(out_data[31:0]), 128'h11);
        tick();
        chk("bp_still_11", 128'(out_data[31:0]), 128'h11);
        chk("bp_still_valid", 128'(out_valid), 128'b0001);
        send(32'h33, 2'd1);
        #1 chk("bp_other_ready", 128'(in_ready), 128'h1);
        tick();
        chk("bp_ch1_valid", 128'(out_valid), 128'b0011);
        chk("bp_ch1_data", 128'(out_data[63:32]), 128'h33);
        send(32'h22, 2'd0);
        out_ready = 4'hF;
        #1 chk("bp_drain_ready", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_22_valid", 128'(out_valid), 128'b0001);
        chk("bp_22_data", 128'(out_data[31:0]), 128'h22);
        tick();
        chk("bp_empty", 128'(out_valid), 128'h0);

        // Drain and refill channel 3 in the same cycle.
        send(32'h55, 2'd3);
        tick();
        send(32'h66, 2'd3);
        #1 chk("refill_ready", 128'(in_ready), 128'h1);
        chk("refill_old", 128'(out_data[127:96]), 128'h55);
        tick();
        in_valid = 1'b0;
        chk("refill_valid", 128'(out_valid), 128'b1000);
        chk("refill_new", 128'(out_data[127:96]), 128'h66);
        tick();

        // Stability of stalled channel 1 while others flow.
        out_ready = 4'b1101;
        send(32'h77, 2'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            send(32'h100 + DW'(i), (i % 3 == 0) ? 2'd0 : ((i % 3 == 1) ? 2'd2 : 2'd3));
            #1;
            chk("stable_data", 128'(out_data[63:32]), 128'h77);
            chk("stable_valid", 128'(out_valid[1]), 128'h1);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 4'hF;
        tick();
        tick();

        // Asynchronous reset while channel 2 is full and stalled.
        out_ready = 4'b1011;
        send(32'h99, 2'd2);
        tick();
        in_valid = 1'b0;
        #1 chk("pre_reset_valid", 128'(out_valid), 128'b0100);
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", 128'(out_valid), 128'h0);
        chk("async_reset_data", out_data, 128'h0);
        for (int d = 0; d < 4; d++) begin
            in_dest = 2'(d);
            #0.1;
            chk("reset_in_ready", 128'(in_ready), 128'h1);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        out_ready = 4'hF;
        tick();

`ifdef DEMUX_BROADCAST_EN
        // Broadcast waits for stalled channel 2, then fills all four.
        out_ready = 4'b1011;
        send(32'h12, 2'd2);
        tick();
        send(32'hBEEF, 2'd0);
        in_bcast = 1'b1;
        #1 chk("bcast_blocked", 128'(in_ready), 128'h0);
        tick();
        chk("bcast_not_taken", 128'(out_valid), 128'b0100);
        out_ready = 4'hF;
        #1 chk("bcast_ready", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0;
        in_bcast = 1'b0;
        chk("bcast_valid", 128'(out_valid), 128'hF);
        chk("bcast_data", out_data, {4{32'hBEEF}});
        tick();
`endif

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_to_4.md
# demux_1_to_4

Registered 1-to-4 stream distributor with valid/ready handshakes on every port. It takes one input word plus a 2-bit destination code and delivers the word to exactly one of four output channels. Each channel has a one-entry holding register, so a stalled consumer blocks only words addressed to that channel. It is the routing counterpart of the 4-to-1 selector and sits wherever one producer (e.g. a write-back or result bus) must feed four independent consumers.

## Interface
- data_width, 32, width of each data word.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  data_width  word to route.
- in_dest  input  2  destination channel: 2'b00→0 (A), 2'b01→1 (B), 2'b10→2 (C), 2'b11→3 (D).
- in_valid  input  1  in_data/in_dest valid this cycle.
- in_ready  output  1  block accepts the offered word this cycle.
- in_bcast  input  1  broadcast request; present only with DEMUX_BROADCAST_EN.
- out_data  output  4*data_width  channel k occupies bits [k*data_width +: data_width].
- out_valid  output  4  per-channel holding register full.
- out_ready  input  4  per-channel consumer ready.

## Operation
- Per channel k: state EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1). Holding data register hold[k].
- Input transfer: in_valid && in_ready at a rising edge. Output transfer k: out_valid[k] && out_ready[k] at a rising edge.
- in_ready = !out_valid[in_dest] || out_ready[in_dest]. This is combinational from in_dest, out_valid and out_ready. It does not depend on in_valid.
- On input transfer to channel d: hold[d] ← in_data and out_valid[d] ← 1, even if channel d is draining the same cycle (simultaneous drain+refill, no bubble).
- On output transfer k with no refill of k: out_valid[k] ← 0. hold[k] keeps its stale value.
- Channels other than d are unaffected. Multiple channels may drain in the same cycle.
- Transitions per channel: EMPTY→FULL on write. FULL→EMPTY on drain without write. FULL→FULL on drain+write or on idle. EMPTY→EMPTY otherwise.
- No reordering within a channel. Words to different channels are independent.
- out_data[k] is driven directly from hold[k]. It must stay stable while out_valid[k]=1 and out_ready[k]=0.
- in_dest is ignored when in_valid=0.

## Timing
- Reset (reset_n=0, asynchronous): out_valid=4'b0000 and every hold[k]=0, so out_data=0. Words held when reset asserts are discarded.
- Values are released on the first rising clk edge after reset_n returns high.
- Latency: a word accepted at edge N appears on out_valid/out_data of its channel right after edge N (1 cycle).
- Throughput: 1 word/cycle to any channel whose consumer keeps out_ready=1.
- No combinational path from in_data to out_data. in_ready has a combinational path from out_ready.

## Configuration
- DEMUX_BROADCAST_EN defined: the in_bcast port exists.
  - When in_valid && in_bcast, in_dest is ignored.
  - in_ready = AND over k of (!out_valid[k] || out_ready[k]).
  - On transfer, all four hold registers load in_data and out_valid ← 4'b1111.
  - Unicast behaviour is unchanged when in_bcast=0.
- DEMUX_BROADCAST_EN undefined: the in_bcast port is absent. Only unicast routing exists.

## Test plan
- Reset: hold reset_n=0 mid-stream with channel 2 FULL → out_valid=4'b0000 and out_data=0 immediately, without waiting for clk. in_ready=1 for every in_dest.
- Routing: send 0xA0000000..0xA0000003 with in_dest 0..3 and all out_ready=1 → each word appears one cycle later on its own channel only, with exactly one out_valid bit high per cycle.
- Backpressure isolation: out_ready=4'b1110, send 0x11 then 0x22 to channel 0 → 0x11 is held and in_ready=0 for dest 0. A following 0x33 to dest 1 is accepted and delivered. Raising out_ready[0] drains 0x11, then 0x22 is accepted.
- Drain+refill: channel 3 FULL with 0x55 and out_ready[3]=1, offer 0x66 to dest 3 in the same cycle → accepted. The next cycle shows 0x66 with out_valid[3] still 1 (no bubble).
- Stability: channel 1 FULL with out_ready[1]=0 for 10 cycles while other traffic flows → out_data[1] is unchanged and out_valid[1]=1 throughout.
- Broadcast (DEMUX_BROADCAST_EN): with channel 2 FULL and stalled, offer in_bcast with 0xBEEF → in_ready=0. After channel 2 drains, the word is accepted and all four channels show 0xBEEF with out_valid=4'b1111.
